// File: rtl/adder_pkg.sv
// adder_pkg: shared width constants and the registered result type for adder_unit.
//   ADDER_WIDTH_DEFAULT : default operand width
//   ADDER_WIDTH_MAX     : widest legal operand, sizes the sum field of the result
//   adder_result_t      : {sum, cout[, ovf]} held in the output register
//   ADDER_OVERFLOW_EN   : when defined, the result carries a signed-overflow bit
package adder_pkg;
   localparam int ADDER_WIDTH_DEFAULT = 2;
   localparam int ADDER_WIDTH_MAX     = 64;
   typedef struct packed {
      logic [ADDER_WIDTH_MAX-1:0] sum;
      logic                       cout;
`ifdef ADDER_OVERFLOW_EN
      logic                       ovf;
`endif
   } adder_result_t;
endpackage

// File: rtl/adder_unit_full_adder.sv
// full_adder: one-bit full-adder cell of the ripple chain.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit a^b^ci
//   co   : carry out, majority(a,b,ci)
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/adder_unit.sv
// adder_unit: registered WIDTH-bit ripple-carry adder with carry-in/carry-out.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, dominates in_valid
//   in_valid  : capture lhs/rhs/cin this edge
//   lhs, rhs  : unsigned operands
//   cin       : carry in
//   out_valid : out/cout hold a fresh result for this one cycle
//   out, cout : registered sum and carry out of lhs+rhs+cin
//   ovf       : registered two's-complement overflow (only with ADDER_OVERFLOW_EN)
module adder_unit
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             cout
`ifdef ADDER_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   adder_result_t    res_d, res_q;
   logic             valid_d, valid_q;
   logic             unused_sum;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a (lhs[i]),
         .b (rhs[i]),
         .ci(c[i]),
         .s (s[i]),
         .co(c[i+1])
      );
   end

   always_comb begin
      res_d   = res_q;
      valid_d = in_valid;
      if (in_valid) begin
         res_d                = '0;
         res_d.sum[WIDTH-1:0] = s;
         res_d.cout           = c[WIDTH];
`ifdef ADDER_OVERFLOW_EN
         // carry into the MSB cell differs from carry out of it
         res_d.ovf            = c[WIDTH-1] ^ c[WIDTH];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid  = valid_q;
   assign out        = res_q.sum[WIDTH-1:0];
   assign cout       = res_q.cout;
   // sum bits above WIDTH are always zero
   assign unused_sum = ^res_q.sum;
`ifdef ADDER_OVERFLOW_EN
   assign ovf        = res_q.ovf;
`endif
endmodule

// File: tb/tb_adder_unit.sv
// tb_adder_unit: self-checking bench for adder_unit against an arithmetic reference model.
module tb_adder_unit;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         reset, in_valid, cin;
   logic [W-1:0] lhs, rhs;
   logic         out_valid, cout;
   logic [W-1:0] out;
`ifdef ADDER_OVERFLOW_EN
   logic         ovf;
   logic         m_ovf;
`endif

   int           m_out, m_cout, m_v;
   int           vectors = 0;
   int           miscompares = 0;

   adder_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .lhs      (lhs),
      .rhs      (rhs),
      .cin      (cin),
      .out_valid(out_valid),
      .out      (out),
      .cout     (cout)
`ifdef ADDER_OVERFLOW_EN
      ,
      .ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input int a, input int b, input int c);
      int sum, sa, sb, ss;
      reset    = r;
      in_valid = v;
      lhs      = W'(a);
      rhs      = W'(b);
      cin      = c[0];
      @(posedge clk);
      if (r) begin
         m_out = 0; m_cout = 0; m_v = 0;
`ifdef ADDER_OVERFLOW_EN
         m_ovf = 1'b0;
`endif
      end else if (v) begin
         sum    = a + b + c;
         m_out  = sum % (1 << W);
         m_cout = sum / (1 << W);
         m_v    = 1;
`ifdef ADDER_OVERFLOW_EN
         sa    = (a >= (1 << (W-1))) ? a - (1 << W) : a;
         sb    = (b >= (1 << (W-1))) ? b - (1 << W) : b;
         ss    = sa + sb + c;
         m_ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
`endif
      end else begin
         m_v = 0;
      end
      #1;
      chk("out", longint'(out), longint'(m_out));
      chk("cout", longint'(cout), longint'(m_cout));
      chk("out_valid", longint'(out_valid), longint'(m_v));
`ifdef ADDER_OVERFLOW_EN
      chk("ovf", longint'(ovf), longint'(m_ovf));
`endif
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; lhs = '0; rhs = '0; cin = 1'b0;
      m_out = 0; m_cout = 0; m_v = 0;
`ifdef ADDER_OVERFLOW_EN
      m_ovf = 1'b0;
`endif
      step(1, 1, 3, 3, 1);
      step(1, 1, 3, 3, 1);
      chk("reset_out", longint'(out), 0);
      step(0, 1, 1, 3, 1);
      chk("basic_out", longint'(out), 1);
      chk("basic_cout", longint'(cout), 1);
      step(0, 1, 1, 1, 0);
      chk("nocarry_out", longint'(out), 2);
      step(0, 0, 0, 0, 0);
      chk("hold_out", longint'(out), 2);
      chk("hold_valid", longint'(out_valid), 0);
      step(0, 1, 3, 3, 1);
      chk("max_out", longint'(out), 3);
      step(0, 1, 0, 0, 0);
      step(0, 1, 2, 1, 0);
      step(0, 1, 3, 2, 1);
      chk("b2b_out", longint'(out), 2);
      step(0, 1, 0, 3, 1);
      step(1, 1, 2, 2, 0);
      chk("midreset_valid", longint'(out_valid), 0);
      step(0, 1, 2, 2, 0);
`ifdef ADDER_OVERFLOW_EN
      step(0, 1, 1, 1, 0);
      chk("ovf_pos", longint'(ovf), 1);
      step(0, 1, 3, 3, 0);
      chk("ovf_neg", longint'(ovf), 0);
`endif
      for (int a = 0; a < (1 << W); a++)
         for (int b = 0; b < (1 << W); b++)
            for (int c = 0; c < 2; c++)
               step(0, 1, a, b, c);
      for (int k = 0; k < 300; k++)
         step(($urandom_range(19) == 0), ($urandom_range(3) != 0),
              int'($urandom_range((1 << W) - 1)), int'($urandom_range((1 << W) - 1)),
              int'($urandom_range(1)));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
